audio_dac_i2s_tx: RTL and testbench

- I2S transmitter for the DAC path: the serialising end of the audio codec write interface.
- Accepts stereo parallel samples from a `system` instance through a `write`/`write_ready` handshake and buffers them in a 2-entry FIFO.
- Shifts each sample out on `aud_dacdat`, timed by the codec-mastered `AUD_BCLK` and `AUD_DACLRCK`.
- Runs entirely in the 50 MHz system clock domain; the codec clocks are oversampled, not used as clocks.

---
 rtl/audio_dac_i2s_tx_pkg.sv | 13 +
 rtl/audio_dac_i2s_tx_if.sv | 15 +
 rtl/audio_dac_i2s_tx_clk_sync.sv | 30 +++
 rtl/audio_dac_i2s_tx.sv | 115 +++++++++++
 tb/tb_audio_dac_i2s_tx.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/audio_dac_i2s_tx_pkg.sv
// audio_pkg: shared audio types and constants.
// Provides the default sample width, the stereo sample struct and the LRCK channel encodings.
package audio_pkg;
    localparam int AUDIO_DATA_W = 24;

    typedef struct packed {
        logic [AUDIO_DATA_W-1:0] left;
        logic [AUDIO_DATA_W-1:0] right;
    } stereo_sample_t;

    localparam logic LR_LEFT  = 1'b0;
    localparam logic LR_RIGHT = 1'b1;
endpackage

// File: rtl/audio_dac_i2s_tx_if.sv
// audio_dac_i2s_tx_if: stereo sample write bus.
// write/writedata_left/writedata_right: driven by master; write_ready: driven by slave (FIFO not full).
interface audio_dac_i2s_tx_if
    import audio_pkg::*;
#(
    parameter int DATA_W = AUDIO_DATA_W
) ();
    logic              write;
    logic [DATA_W-1:0] writedata_left;
    logic [DATA_W-1:0] writedata_right;
    logic              write_ready;

    modport master (output write, writedata_left, writedata_right, input write_ready);
    modport slave  (input write, writedata_left, writedata_right, output write_ready);
endinterface

// File: rtl/audio_dac_i2s_tx_clk_sync.sv
// audio_clk_sync: multi-stage synchroniser for a slow codec clock with edge pulses.
// Ports: clk, rst_n (async active-low), d (async input), level (synchronised),
// rise/fall (one-clk pulses on synchronised edges).
module audio_clk_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], d};
            prev <= sync[STAGES-1];
        end
    end

    assign level = sync[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;
endmodule

// File: rtl/audio_dac_i2s_tx.sv
// audio_dac_i2s_tx: I2S DAC transmitter with a small stereo FIFO, oversampling codec BCLK/LRCK.
// Ports: clk, rst_n (async active-low), bus (write handshake, slave side),
// aud_bclk/aud_daclrck (codec clocks, async), aud_dacdat (serial data),
// underrun (empty FIFO at left boundary), frame_start (left word loaded).
module audio_dac_i2s_tx
    import audio_pkg::*;
#(
    parameter int DATA_W      = AUDIO_DATA_W,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    audio_dac_i2s_tx_if.slave    bus,
    input  logic                 aud_bclk,
    input  logic                 aud_daclrck,
    output logic                 aud_dacdat,
    output logic                 underrun,
    output logic                 frame_start
);
    localparam int CW = $clog2(DATA_W);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic bclk_level, bclk_rise, bclk_fall;
    logic lrck, lr_rise, lr_fall;
    logic unused_sync;

    audio_clk_sync #(.STAGES(SYNC_STAGES)) u_bclk_sync (
        .clk(clk), .rst_n(rst_n), .d(aud_bclk), .level(bclk_level), .rise(bclk_rise), .fall(bclk_fall)
    );
    audio_clk_sync #(.STAGES(SYNC_STAGES)) u_lrck_sync (
        .clk(clk), .rst_n(rst_n), .d(aud_daclrck), .level(lrck), .rise(lr_rise), .fall(lr_fall)
    );
    assign unused_sync = bclk_level ^ lr_rise ^ lr_fall;

    logic [DATA_W-1:0] mem_l [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count, count_next;
    logic              lr_valid, lr_prev, boundary_pending, new_ch;
    logic [DATA_W-1:0] shifter, hold, load_word;
    logic [CW-1:0]     bit_cnt;
    logic              push, pop, load;

    assign push       = bus.write && bus.write_ready;
    assign load       = bclk_fall && boundary_pending;
    assign pop        = load && new_ch == LR_LEFT && count != '0;
    assign count_next = count + (AW+1)'(push) - (AW+1)'(pop);
    // An empty FIFO at a left boundary loads silence rather than replaying old data.
    assign load_word  = new_ch == LR_LEFT ? (pop ? mem_l[rd_ptr] : '0) : hold;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_l[wr_ptr] <= bus.writedata_left;
            mem_r[wr_ptr] <= bus.writedata_right;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            bus.write_ready  <= 1'b1;
            lr_valid         <= 1'b0;
            lr_prev          <= 1'b0;
            boundary_pending <= 1'b0;
            new_ch           <= LR_LEFT;
            shifter          <= '0;
            hold             <= '0;
            bit_cnt          <= '0;
            aud_dacdat       <= 1'b0;
            underrun         <= 1'b0;
            frame_start      <= 1'b0;
        end else begin
            underrun    <= 1'b0;
            frame_start <= 1'b0;
            // LRCK is only trusted at BCLK rises; the first one just seeds lr_prev so a
            // reset released mid-frame never sees a false boundary.
            if (bclk_rise) begin
                if (!lr_valid) begin
                    lr_valid <= 1'b1;
                end else if (lrck != lr_prev) begin
                    boundary_pending <= 1'b1;
                    new_ch           <= lrck;
                end
                lr_prev <= lrck;
            end
            // Loading on the fall after the boundary rise gives the I2S one-bit delay.
            if (bclk_fall) begin
                if (boundary_pending) begin
                    boundary_pending <= 1'b0;
                    shifter          <= load_word;
                    aud_dacdat       <= load_word[DATA_W-1];
                    bit_cnt          <= CW'(DATA_W-1);
                    if (new_ch == LR_LEFT) begin
                        hold        <= pop ? mem_r[rd_ptr] : '0;
                        frame_start <= pop;
                        underrun    <= !pop;
                    end
                end else if (bit_cnt != '0) begin
                    shifter    <= shifter << 1;
                    aud_dacdat <= shifter[DATA_W-2];
                    bit_cnt    <= bit_cnt - CW'(1);
                end else begin
                    aud_dacdat <= 1'b0;
                end
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count           <= count_next;
            bus.write_ready <= count_next != (AW+1)'(FIFO_DEPTH);
        end
    end
endmodule

// File: tb/tb_audio_dac_i2s_tx.sv
// tb_audio_dac_i2s_tx: scoreboard bench for the I2S DAC transmitter.
// Drives BCLK = clk/16 with 64 BCLK per frame, models the FIFO as a queue of stereo
// pairs and decodes the serial stream at each BCLK rise into whole frames.
module tb_audio_dac_i2s_tx;
    import audio_pkg::*;

    localparam int DW    = 24;
    localparam int DEPTH = 2;

    logic clk = 1'b0, rst_n = 1'b0, aud_bclk = 1'b0, aud_daclrck = 1'b0;
    logic aud_dacdat, underrun, frame_start;

    audio_dac_i2s_tx_if #(.DATA_W(DW)) bus ();

    audio_dac_i2s_tx #(.DATA_W(DW), .SYNC_STAGES(2), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .aud_bclk(aud_bclk), .aud_daclrck(aud_daclrck),
        .aud_dacdat(aud_dacdat), .underrun(underrun), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        int            fs;
        int            ur;
    } frame_t;

    frame_t          exp_q[$];
    logic [2*DW-1:0] mq[$];
    int              checks = 0, errors = 0;
    logic [9:0]      ph = '0;
    int              frame_no = 0;
    bit              model_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Codec clock source; at each LRCK fall the model decides what the frame carries.
    initial begin
        logic [2*DW-1:0] p;
        forever begin
            @(negedge clk);
            ph = ph + 10'd1;
            if (ph == 10'd0) frame_no++;
            aud_bclk    = ph[3];
            aud_daclrck = ph[9];
            if (ph == 10'd19 && model_on) begin
                if (mq.size() != 0) begin
                    p = mq.pop_front();
                    exp_q.push_back('{p[2*DW-1:DW], p[DW-1:0], 1, 0});
                end else begin
                    exp_q.push_back('{'0, '0, 0, 1});
                end
            end
        end
    end

    int fs_tot = 0, ur_tot = 0, fs_snap = 0, ur_snap = 0;
    always @(negedge clk) begin
        if (frame_start) fs_tot++;
        if (underrun) ur_tot++;
    end

    // Monitor: the bit seen at rise fb belongs to frame bit fb-1 (one-bit delay).
    logic          bits[64];
    bit            rst_frame = 1'b0, post_or = 1'b0;
    int            fb, d;
    frame_t        e;
    logic [DW-1:0] got_l, got_r;
    logic          pad;
    always @(posedge aud_bclk) begin
        fb = int'(ph[9:4]);
        d = (fb + 63) % 64;
        bits[d] = aud_dacdat;
        if (rst_frame) post_or = post_or | aud_dacdat;
        if (fb == 0) begin
            if (rst_frame) begin
                chk("post_reset_silent", 64'(post_or), 64'd0);
                rst_frame = 1'b0;
                post_or = 1'b0;
            end else if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                pad = 1'b0;
                for (int i = 0; i < DW; i++) begin
                    got_l[DW-1-i] = bits[i];
                    got_r[DW-1-i] = bits[32+i];
                end
                for (int i = DW; i < 32; i++) pad = pad | bits[i] | bits[32+i];
                chk("left_word", 64'(got_l), 64'(e.l));
                chk("right_word", 64'(got_r), 64'(e.r));
                chk("slot_padding", 64'(pad), 64'd0);
                chk("frame_start_pulses", 64'(fs_tot - fs_snap), 64'(e.fs));
                chk("underrun_pulses", 64'(ur_tot - ur_snap), 64'(e.ur));
            end
            fs_snap = fs_tot;
            ur_snap = ur_tot;
        end
    end

    task automatic wait_ph(input int p);
        int n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (int'(ph) != p - 1 && n < 4096);
        if (n >= 4096) begin
            checks++;
            errors++;
            $display("FAIL wait_ph timeout: phase %0d required %0d", ph, p);
        end
        @(negedge clk);
    endtask

    task automatic wait_frame(input int f);
        int n = 0;
        while (frame_no < f && n < 8192) begin
            @(posedge clk);
            n++;
        end
        if (frame_no < f) begin
            checks++;
            errors++;
            $display("FAIL wait_frame timeout: frame %0d required %0d", frame_no, f);
        end
    endtask

    task automatic do_write(input logic [DW-1:0] l, input logic [DW-1:0] r);
        bit acc;
        acc = mq.size() < DEPTH;
        chk("write_ready", 64'(bus.write_ready), 64'(acc));
        if (acc) mq.push_back({l, r});
        bus.write           = 1'b1;
        bus.writedata_left  = l;
        bus.writedata_right = r;
        @(negedge clk);
        bus.write = 1'b0;
    endtask

    initial begin
        bus.write           = 1'b0;
        bus.writedata_left  = '0;
        bus.writedata_right = '0;
        repeat (3) @(negedge clk);
        chk("reset_write_ready", 64'(bus.write_ready), 64'd1);
        chk("reset_dacdat", 64'(aud_dacdat), 64'd0);
        chk("reset_underrun", 64'(underrun), 64'd0);
        chk("reset_frame_start", 64'(frame_start), 64'd0);
        rst_n = 1'b1;
        wait_frame(1);
        model_on = 1'b1;
        wait_ph(100);
        do_write(24'hA5A5A5, 24'h0F0F0F);
        wait_frame(2);
        wait_ph(300);
        repeat (3) do_write(24'($urandom()), 24'($urandom()));
        wait_frame(4);
        wait_ph(18);
        do_write(24'($urandom()), 24'($urandom()));
        wait_ph(30);
        chk("ready_after_pushpop", 64'(bus.write_ready), 64'(mq.size() < DEPTH));
        for (int f = 5; f < 9; f++) begin
            wait_frame(f);
            if ($urandom_range(0, 2) != 0) begin
                wait_ph(int'($urandom_range(100, 900)));
                do_write(24'($urandom()), 24'($urandom()));
            end
        end
        wait_frame(9);
        wait_ph(200);
        do_write(24'h7FFFFF, 24'h800000);
        wait_frame(10);
        wait_ph(200);
        do_write(24'h800000, 24'h7FFFFF);
        wait_frame(12);
        wait_ph(200);
        rst_n = 1'b0;
        mq.delete();
        exp_q.delete();
        post_or = 1'b0;
        rst_frame = 1'b1;
        #1;
        chk("midframe_reset_dacdat", 64'(aud_dacdat), 64'd0);
        chk("midframe_reset_ready", 64'(bus.write_ready), 64'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_ph(600);
        do_write(24'h800001, 24'($urandom()));
        wait_frame(15);
        model_on = 1'b0;
        wait_ph(50);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
